// File: rtl/game_step_ctrl.sv
// Step controller for a snake-style game. A free-running tick counter paces
// the game; at each step the requested direction is latched (reversals are
// refused) and the datapath is asked to advance one cell. The controller
// then waits for the datapath to finish, bounded by a timeout.
//
// Handshake move_req/dp_ack: move_req is raised on the first MOVE clock and
// held high until a clock edge samples dp_ack=1. That edge completes the
// transfer, and move_req is low on the following clock. collide and ate are
// only looked at on that same edge. dp_ack, collide and ate are ignored in
// every other state.
module game_step_ctrl #(
  parameter int BASE_PERIOD = 16777216,
  parameter int CNT_W       = 25,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic [1:0]  speed,
  input  logic [1:0]  dir_in,
  input  logic        dp_ack,
  input  logic        collide,
  input  logic        ate,
  output logic [1:0]  dir_out,
  output logic        move_req,
  output logic        grow,
  output logic [15:0] step_cnt,
  output logic        game_over,
  output logic        ack_err,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_LATCH = 3'd2,
    S_MOVE  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  // One extra bit so that BASE_PERIOD itself is representable even when the
  // counter only holds BASE_PERIOD-1.
  localparam logic [CNT_W:0] BASE_P = (CNT_W + 1)'(BASE_PERIOD);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic [ACK_W-1:0] ack_cnt;

  logic [CNT_W:0]   period;
  logic [CNT_W:0]   period_m1;
  logic             count_done;
  logic             reversal;
  logic             ack_last;

  assign state_dbg = state;

  // Step period follows speed every clock, so a speed-up mid-count can end
  // the current count early (>= rather than == in the compare).
  always_comb begin
    period     = BASE_P >> speed;
    period_m1  = period - {{CNT_W{1'b0}}, 1'b1};
    count_done = ({1'b0, tick_cnt} >= period_m1);
    reversal   = (dir_in == (dir_out ^ 2'b10));
    ack_last   = (ack_cnt == ACK_LAST);
  end

  // Main controller: state, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      ack_cnt   <= '0;
      dir_out   <= 2'b01;
      move_req  <= 1'b0;
      grow      <= 1'b0;
      step_cnt  <= 16'd0;
      game_over <= 1'b0;
      ack_err   <= 1'b0;
    end else begin
      // grow is a single-clock pulse unless re-asserted below.
      grow <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            tick_cnt  <= '0;
            ack_cnt   <= '0;
            step_cnt  <= 16'd0;
            dir_out   <= 2'b01;
            game_over <= 1'b0;
            ack_err   <= 1'b0;
            state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (!pause) begin
            if (count_done) begin
              tick_cnt <= '0;
              state    <= S_LATCH;
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end

        S_LATCH: begin
          // Turning straight back onto the body is refused; keep heading.
          if (!reversal) begin
            dir_out <= dir_in;
          end
          ack_cnt  <= '0;
          move_req <= 1'b1;
          state    <= S_MOVE;
        end

        S_MOVE: begin
          if (dp_ack) begin
            move_req <= 1'b0;
            ack_cnt  <= '0;
            if (collide) begin
              // A fatal move does not count and never grows the snake.
              game_over <= 1'b1;
              state     <= S_HALT;
            end else begin
              if (step_cnt != 16'hFFFF) begin
                step_cnt <= step_cnt + 16'd1;
              end
              grow     <= ate;
              tick_cnt <= '0;
              state    <= S_WAIT;
            end
          end else if (ack_last) begin
            // Datapath never answered: give up and flag it.
            move_req  <= 1'b0;
            game_over <= 1'b1;
            ack_err   <= 1'b1;
            state     <= S_HALT;
          end else begin
            ack_cnt <= ack_cnt + ACK_W'(1);
          end
        end

        S_HALT: begin
          // Restart goes straight to WAIT with a fresh game.
          if (start) begin
            tick_cnt  <= '0;
            ack_cnt   <= '0;
            step_cnt  <= 16'd0;
            dir_out   <= 2'b01;
            game_over <= 1'b0;
            ack_err   <= 1'b0;
            state     <= S_WAIT;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_step_ctrl.sv
// Directed bench for game_step_ctrl with a short step period and timeout.
module tb_game_step_ctrl;

  localparam int BASE_PERIOD = 16;
  localparam int CNT_W       = 5;
  localparam int ACK_TIMEOUT = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_MOVE  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic        start;
  logic        pause;
  logic [1:0]  speed;
  logic [1:0]  dir_in;
  logic        dp_ack;
  logic        collide;
  logic        ate;
  logic [1:0]  dir_out;
  logic        move_req;
  logic        grow;
  logic [15:0] step_cnt;
  logic        game_over;
  logic        ack_err;
  logic [2:0]  state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  game_step_ctrl #(
    .BASE_PERIOD (BASE_PERIOD),
    .CNT_W       (CNT_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .speed     (speed),
    .dir_in    (dir_in),
    .dp_ack    (dp_ack),
    .collide   (collide),
    .ate       (ate),
    .dir_out   (dir_out),
    .move_req  (move_req),
    .grow      (grow),
    .step_cnt  (step_cnt),
    .game_over (game_over),
    .ack_err   (ack_err),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] exp_steps;
  int          n_assert;
  int          n_fail;
  int          n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count clocks until move_req is seen high, bounded.
  task automatic wait_move_req(output int cnt);
    cnt = 0;
    while (move_req !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  // Hold off dp_ack for 'extra' clocks, then complete the transfer.
  task automatic handshake(input int extra, input logic a, input logic c);
    logic [15:0] got;
    repeat (extra) tick();
    dp_ack  = 1'b1;
    ate     = a;
    collide = c;
    if (!c && exp_steps != 16'hFFFF) exp_steps = exp_steps + 16'd1;
    exp_q.push_back(exp_steps);
    tick();
    dp_ack  = 1'b0;
    ate     = 1'b0;
    collide = 1'b0;
    got = exp_q.pop_front();
    check("step_cnt", {16'd0, step_cnt}, {16'd0, got});
    check("move_req_drop", {31'd0, move_req}, 32'd0);
    check("grow_pulse", {31'd0, grow}, {31'd0, a & ~c});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_assert  = 0;
    n_fail    = 0;
    exp_steps = 16'd0;
    rst     = 1'b0;
    start   = 1'b0;
    pause   = 1'b0;
    speed   = 2'd0;
    dir_in  = 2'b01;
    dp_ack  = 1'b0;
    collide = 1'b0;
    ate     = 1'b0;

    // Reset values
    #12;
    check("rst_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    check("rst_dir", {30'd0, dir_out}, 32'd1);
    check("rst_move_req", {31'd0, move_req}, 32'd0);
    check("rst_outputs", {13'd0, step_cnt, grow, game_over, ack_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) tick();
    check("idle_hold", {29'd0, state_dbg}, {29'd0, ST_IDLE});

    // Start and regular stepping: 16 WAIT + 1 LATCH + 3 MOVE
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_wait", {29'd0, state_dbg}, {29'd0, ST_WAIT});
    wait_move_req(n);
    check("first_latency", n, 17);
    for (int i = 0; i < 3; i++) begin
      handshake(2, 1'b0, 1'b0);
      wait_move_req(n);
      check("step_period", n + 3, 20);
    end

    // Direction: change outside LATCH ignored, reversal refused, turn taken
    dir_in = 2'b11;
    check("dir_hold_move", {30'd0, dir_out}, 32'd1);
    handshake(2, 1'b0, 1'b0);
    check("dir_outside_latch", {30'd0, dir_out}, 32'd1);
    wait_move_req(n);
    check("dir_reversal", {30'd0, dir_out}, 32'd1);
    dir_in = 2'b00;
    handshake(2, 1'b0, 1'b0);
    wait_move_req(n);
    check("dir_turn_up", {30'd0, dir_out}, 32'd0);
    dir_in = 2'b01;
    handshake(0, 1'b0, 1'b0);
    check("dir_after_move", {30'd0, dir_out}, 32'd0);

    // pause ignored in MOVE, then a 40-clock pause mid-WAIT
    wait_move_req(n);
    pause = 1'b1;
    handshake(1, 1'b0, 1'b0);
    pause = 1'b0;
    repeat (5) tick();
    pause = 1'b1;
    repeat (40) tick();
    check("pause_hold", {29'd0, state_dbg}, {29'd0, ST_WAIT});
    pause = 1'b0;
    wait_move_req(n);
    check("pause_delay", n, 12);

    // Speed change with counter past the new terminal value
    handshake(2, 1'b0, 1'b0);
    repeat (5) tick();
    speed = 2'd3;
    tick();
    check("speed_latch", {29'd0, state_dbg}, {29'd0, ST_LATCH});
    wait_move_req(n);
    check("speed_move", n, 1);
    speed = 2'd0;

    // Eat: grow single pulse; then eat+collide: halt, no grow
    handshake(2, 1'b1, 1'b0);
    tick();
    check("grow_single", {31'd0, grow}, 32'd0);
    wait_move_req(n);
    handshake(2, 1'b1, 1'b1);
    check("collide_over", {31'd0, game_over}, 32'd1);
    check("collide_halt", {29'd0, state_dbg}, {29'd0, ST_HALT});
    dp_ack = 1'b1;
    repeat (3) tick();
    dp_ack = 1'b0;
    check("halt_hold", {15'd0, step_cnt, game_over}, {15'd0, exp_steps, 1'b1});

    // Restart from HALT
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_steps = 16'd0;
    check("restart", {13'd0, step_cnt, game_over, ack_err, 1'b0}, 32'd0);
    check("restart_wait", {29'd0, state_dbg}, {29'd0, ST_WAIT});

    // dp_ack/collide and start ignored in WAIT: count carries on
    dp_ack = 1'b1; collide = 1'b1; start = 1'b1;
    repeat (2) tick();
    dp_ack = 1'b0; collide = 1'b0; start = 1'b0;
    check("wait_ignore", {30'd0, state_dbg[1:0] ^ 2'b00, game_over}, {30'd0, 2'b01, 1'b0});
    wait_move_req(n);
    check("wait_ignore_timing", n, 15);

    // Timeout: 8 MOVE clocks with no dp_ack
    repeat (7) tick();
    check("timeout_pending", {30'd0, move_req, game_over}, 32'd2);
    tick();
    check("timeout_flags", {29'd0, move_req, game_over, ack_err}, 32'd3);
    check("timeout_halt", {29'd0, state_dbg}, {29'd0, ST_HALT});
    start = 1'b1;
    tick();
    start = 1'b0;
    check("timeout_restart", {13'd0, step_cnt, game_over, ack_err, 1'b0}, 32'd0);

    // Asynchronous reset mid-handshake
    wait_move_req(n);
    handshake(2, 1'b0, 1'b0);
    dir_in = 2'b10;
    wait_move_req(n);
    check("pre_rst_dir", {30'd0, dir_out}, 32'd2);
    #3;
    rst = 1'b0;
    #1;
    check("async_move_req", {31'd0, move_req}, 32'd0);
    check("async_outputs", {13'd0, step_cnt, game_over, ack_err, grow}, 32'd0);
    check("async_dir", {30'd0, dir_out}, 32'd1);
    check("async_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) tick();
    check("post_rst_idle", {28'd0, state_dbg, move_req}, {28'd0, ST_IDLE, 1'b0});

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/game_step_ctrl.md
GAME_STEP_CTRL -- requirements
Module: game_step_ctrl

Interface
REQ-001 Parameter BASE_PERIOD, default 16777216, clocks per game step at speed 0; minimum 8.
REQ-002 Parameter CNT_W, default 25, width of tick counter; SHALL hold BASE_PERIOD-1.
REQ-003 Parameter ACK_TIMEOUT, default 255, max clocks move_req may wait for dp_ack.
REQ-004 clk  in  1  master clock, 100 MHz.
REQ-005 rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-006 start  in  1  level; begins or restarts a game.
REQ-007 pause  in  1  level; freezes the step timer.
REQ-008 speed  in  2  step-rate select; period = BASE_PERIOD >> speed.
REQ-009 dir_in  in  2  requested direction: 00 up, 01 right, 10 down, 11 left.
REQ-010 dp_ack  in  1  datapath finished the move.
REQ-011 collide  in  1  move hit wall/body; valid only with dp_ack.
REQ-012 ate  in  1  move ate food; valid only with dp_ack.
REQ-013 dir_out  out  2  committed direction presented to the datapath.
REQ-014 move_req  out  1  request for the datapath to advance one cell.
REQ-015 grow  out  1  one-cycle pulse; lengthen snake.
REQ-016 step_cnt  out  16  completed steps, saturating.
REQ-017 game_over  out  1  high in HALT.
REQ-018 ack_err  out  1  high when HALT was entered by timeout.

Function
REQ-019 States SHALL be IDLE, WAIT, LATCH, MOVE, HALT.
REQ-020 IDLE: start=1 -> WAIT; tick counter=0, step_cnt=0, dir_out=01, game_over=0, ack_err=0.
REQ-021 WAIT, pause=1: counter holds, no transition.
REQ-022 WAIT, pause=0: counter increments each clock; on counter >= period-1, counter<=0 and -> LATCH.
REQ-023 Period SHALL be re-evaluated every clock; a speed change mid-count with counter already >= new period-1 SHALL terminate the count on the next unpaused clock.
REQ-024 LATCH (exactly 1 clock): dir_out<=dir_in unless dir_in == dir_out XOR 2'b10 (reversal), in which case dir_out holds; -> MOVE.
REQ-025 MOVE: move_req=1 from the first MOVE cycle until the cycle dp_ack=1 is sampled; move_req=0 the following clock.
REQ-026 On dp_ack with collide=1: -> HALT, game_over=1; collide takes priority over ate; no grow, step_cnt unchanged.
REQ-027 On dp_ack with collide=0: step_cnt+1 (saturate at 16'hFFFF); grow=1 for one clock iff ate=1; -> WAIT with counter=0.
REQ-028 pause SHALL be ignored in LATCH and MOVE; the handshake always completes.
REQ-029 MOVE without dp_ack for ACK_TIMEOUT consecutive clocks -> HALT, game_over=1, ack_err=1, move_req=0.
REQ-030 dp_ack, collide, ate SHALL be ignored outside MOVE.
REQ-031 start SHALL be ignored in WAIT, LATCH, MOVE.
REQ-032 HALT: outputs hold; start=1 -> same initialisation as REQ-020 and -> WAIT (no pass through IDLE).
REQ-033 dir_in changes outside LATCH SHALL NOT affect dir_out.

Reset
REQ-034 rst=0 SHALL force immediately, regardless of clk: state IDLE, counter 0, dir_out=01, move_req=0, grow=0, step_cnt=0, game_over=0, ack_err=0.
REQ-035 Reset asserted mid-handshake SHALL drop move_req without waiting for dp_ack.
REQ-036 After rst returns to 1, the block SHALL remain in IDLE until start=1.

Verification (BASE_PERIOD=16, ACK_TIMEOUT=8)
REQ-037 start pulse, speed=0, dp_ack returned 2 clocks after each move_req -> move_req rises every 16+1+3 clocks; step_cnt counts 1,2,3.
REQ-038 dir_out=01, dir_in=11 at LATCH -> dir_out stays 01; dir_in=00 at next LATCH -> dir_out=00.
REQ-039 pause=1 for 40 clocks mid-WAIT -> next move_req delayed by exactly 40 clocks; speed=3 mid-count with counter=5 -> LATCH next clock.
REQ-040 dp_ack with ate=1, collide=0 -> grow single-cycle pulse; dp_ack with ate=1, collide=1 -> no grow, game_over=1, step_cnt unchanged.
REQ-041 dp_ack withheld -> after 8 MOVE clocks game_over=1, ack_err=1, move_req=0; start -> step_cnt=0, game_over=0, WAIT.
REQ-042 rst=0 asserted between clock edges while move_req=1 -> all outputs reach reset values before the next edge.
